// File: rtl/pll_lock_detect.sv
// ---------------------------------------------------------------------------
// pll_lock_detect
//
// Watches the thermometer trim word driven by the PLL controller and decides
// whether the loop has settled. Time is cut into fixed observation windows of
// SAMPLE_CYCLES clocks. At the last cycle of each window the trim level
// (popcount of the trim word) is compared against the level captured at the
// previous window end. LOCK_COUNT consecutive windows whose level moved by at
// most TOL declare lock; an unstable window while locked drops it again.
//
// Any change of the division ratio invalidates the loop immediately: the
// detector returns to UNLOCKED and restarts its window timing from zero.
//
// Build option:
//   PLL_LOCK_HYST_EN  when defined, a locked loop only drops lock after two
//                     consecutive unstable windows; a stable window in
//                     between forgets the first miss. Without it, a single
//                     unstable window drops lock.
// ---------------------------------------------------------------------------
module pll_lock_detect #(
    parameter int SAMPLE_CYCLES = 16,   // clocks per observation window (2..1024)
    parameter int LOCK_COUNT    = 8,    // stable windows needed for lock (1..255)
    parameter int TOL           = 1     // max level step for a stable window (0..26)
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [25:0] trim,
    input  logic [4:0]  div,
    output logic        locked,
    output logic        lock_lost,
    output logic [4:0]  trim_level,
    output logic [1:0]  state
);

    // -----------------------------------------------------------------------
    // Local constants
    // -----------------------------------------------------------------------
    localparam int              WIN_W     = (SAMPLE_CYCLES > 2) ? $clog2(SAMPLE_CYCLES) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(SAMPLE_CYCLES - 1);
    localparam logic [7:0]      LOCK_LAST = 8'(LOCK_COUNT - 1);
    localparam logic [5:0]      TOL_W     = 6'(TOL);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } lock_state_t;

    // -----------------------------------------------------------------------
    // Popcount of the 26-bit thermometer word. The result fits in 5 bits
    // (max 26), so the accumulator never wraps.
    // -----------------------------------------------------------------------
    function automatic logic [4:0] popcount26(input logic [25:0] v);
        logic [4:0] acc;
        acc = '0;
        for (int i = 0; i < 26; i++) begin
            acc = acc + {4'd0, v[i]};
        end
        return acc;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    lock_state_t      state_q;
    logic             locked_q;
    logic             lock_lost_q;
    logic [4:0]       level_q;       // registered popcount, drives trim_level
    logic [4:0]       ref_level;     // level captured at previous window end
    logic [7:0]       stable_cnt;    // consecutive stable windows in ACQUIRE
    logic [WIN_W-1:0] win_cnt;       // free-running window position
    logic [4:0]       div_q;         // div as seen on the previous cycle
`ifdef PLL_LOCK_HYST_EN
    logic             miss_q;        // one unstable window already seen while locked
`endif

    // -----------------------------------------------------------------------
    // Combinational decode
    // -----------------------------------------------------------------------
    logic [4:0] cur_level;
    logic [5:0] level_diff;
    logic       stable;
    logic       win_end;
    logic       div_chg;

    // Current trim level and the stability decision for this window end.
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        cur_level  = popcount26(trim);
        level_diff = '0;
        if ({1'b0, cur_level} >= {1'b0, ref_level}) begin
            level_diff = {1'b0, cur_level} - {1'b0, ref_level};
        end else begin
            level_diff = {1'b0, ref_level} - {1'b0, cur_level};
        end
        stable  = (level_diff <= TOL_W);
        win_end = (win_cnt == WIN_LAST);
        div_chg = (div != div_q);
    end

    // -----------------------------------------------------------------------
    // Registered trim level: popcount of trim with one cycle of latency.
    // NOTE: sequential state is written with non-blocking assignments only,
    // so every register samples the pre-edge values of its sources.
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            level_q <= '0;
        end else begin
            level_q <= cur_level;
        end
    end

    // -----------------------------------------------------------------------
    // Lock FSM with window timer, reference level, div tracking and the
    // registered locked / lock_lost outputs. A div change wins over a window
    // end on the same cycle, so that window is never evaluated.
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= UNLOCKED;
            locked_q    <= 1'b0;
            lock_lost_q <= 1'b0;
            ref_level   <= '0;
            stable_cnt  <= '0;
            win_cnt     <= '0;
            div_q       <= div;
`ifdef PLL_LOCK_HYST_EN
            miss_q      <= 1'b0;
`endif
        end else begin
            div_q       <= div;
            lock_lost_q <= 1'b0;

            if (div_chg) begin
                // New division ratio: the old lock is meaningless.
                state_q     <= UNLOCKED;
                locked_q    <= 1'b0;
                lock_lost_q <= (state_q == LOCKED);
                stable_cnt  <= '0;
                win_cnt     <= '0;
`ifdef PLL_LOCK_HYST_EN
                miss_q      <= 1'b0;
`endif
            end else begin
                win_cnt <= win_end ? '0 : win_cnt + WIN_W'(1);

                if (win_end) begin
                    // Reference always follows the latest window end.
                    ref_level <= cur_level;

                    case (state_q)
                        UNLOCKED: begin
                            // First window only seeds the reference.
                            stable_cnt <= '0;
                            state_q    <= ACQUIRE;
                        end

                        ACQUIRE: begin
                            if (stable) begin
                                if (stable_cnt == LOCK_LAST) begin
                                    state_q    <= LOCKED;
                                    locked_q   <= 1'b1;
                                    stable_cnt <= '0;
`ifdef PLL_LOCK_HYST_EN
                                    miss_q     <= 1'b0;
`endif
                                end else begin
                                    stable_cnt <= stable_cnt + 8'd1;
                                end
                            end else begin
                                stable_cnt <= '0;
                            end
                        end

                        LOCKED: begin
`ifdef PLL_LOCK_HYST_EN
                            if (stable) begin
                                miss_q <= 1'b0;
                            end else if (miss_q) begin
                                state_q     <= UNLOCKED;
                                locked_q    <= 1'b0;
                                lock_lost_q <= 1'b1;
                                stable_cnt  <= '0;
                                miss_q      <= 1'b0;
                            end else begin
                                miss_q <= 1'b1;
                            end
`else
                            if (!stable) begin
                                state_q     <= UNLOCKED;
                                locked_q    <= 1'b0;
                                lock_lost_q <= 1'b1;
                                stable_cnt  <= '0;
                            end
`endif
                        end

                        default: begin
                            // Unused encoding: recover to a known state.
                            state_q    <= UNLOCKED;
                            locked_q   <= 1'b0;
                            stable_cnt <= '0;
                        end
                    endcase
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs (all registered)
    // -----------------------------------------------------------------------
    assign locked     = locked_q;
    assign lock_lost  = lock_lost_q;
    assign trim_level = level_q;
    assign state      = state_q;

endmodule

// File: tb/tb_pll_lock_detect.sv
// ---------------------------------------------------------------------------
// tb_pll_lock_detect
//
// Directed bench for pll_lock_detect with default parameters. Expected output
// snapshots are queued when stimulus is applied and popped for comparison
// once the DUT has advanced the stated number of clock edges. Inputs change
// and outputs are sampled on the falling edge. Edge numbers in the comments
// count rising edges after the first reset release.
// ---------------------------------------------------------------------------
module tb_pll_lock_detect;

    logic        clock;
    logic        reset_n;
    logic [25:0] trim;
    logic [4:0]  div;
    logic        locked;
    logic        lock_lost;
    logic [4:0]  trim_level;
    logic [1:0]  state;

    pll_lock_detect dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .trim       (trim),
        .div        (div),
        .locked     (locked),
        .lock_lost  (lock_lost),
        .trim_level (trim_level),
        .state      (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string      tag;
        logic       locked;
        logic       lock_lost;
        logic [1:0] state;
        logic [4:0] level;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   lost_cnt = 0;

    localparam logic [25:0] TRIM_8  = 26'h00000FF;
    localparam logic [25:0] TRIM_9  = 26'h00001FF;
    localparam logic [25:0] TRIM_10 = 26'h00003FF;
    localparam logic [25:0] TRIM_12 = 26'h0000FFF;
    localparam logic [25:0] TRIM_26 = 26'h3FFFFFF;

    // Count every lock_lost pulse, sampled mid-cycle.
    always @(negedge clock) begin
        if (lock_lost === 1'b1) lost_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic compare(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Queue an expected snapshot, advance n edges, then pop and compare.
    task automatic expect_after(input int n, input string tag, input logic lk,
                                input logic ll, input logic [1:0] st, input logic [4:0] lv);
        exp_t e;
        e.tag = tag; e.locked = lk; e.lock_lost = ll; e.state = st; e.level = lv;
        sb.push_back(e);
        tick(n);
        if (sb.size() == 0) begin
            compare({tag, ".queue"}, 16'd0, 16'd1);
        end else begin
            e = sb.pop_front();
            compare({e.tag, ".locked"},     16'(locked),     16'(e.locked));
            compare({e.tag, ".lock_lost"},  16'(lock_lost),  16'(e.lock_lost));
            compare({e.tag, ".state"},      16'(state),      16'(e.state));
            compare({e.tag, ".trim_level"}, 16'(trim_level), 16'(e.level));
        end
    endtask

    initial begin
        reset_n = 1'b0;
        trim    = TRIM_8;
        div     = 5'd8;

        // Reset state.
        expect_after(3, "reset", 1'b0, 1'b0, 2'd0, 5'd0);

        // Constant trim from release: ACQUIRE at edge 16, lock at edge 144.
        reset_n = 1'b1;
        expect_after(1,   "rel_e1",   1'b0, 1'b0, 2'd0, 5'd8);
        expect_after(14,  "rel_e15",  1'b0, 1'b0, 2'd0, 5'd8);
        expect_after(1,   "rel_e16",  1'b0, 1'b0, 2'd1, 5'd8);
        expect_after(127, "rel_e143", 1'b0, 1'b0, 2'd1, 5'd8);
        expect_after(1,   "rel_e144", 1'b1, 1'b0, 2'd2, 5'd8);
        compare("no_lost_to_lock", 16'(lost_cnt), 16'd0);

        // Level jumps 8 -> 12 after lock: window end at edge 160 drops lock.
        trim = TRIM_12;
        expect_after(15, "jump_e159", 1'b1, 1'b0, 2'd2, 5'd12);
        expect_after(1,  "jump_e160", 1'b0, 1'b1, 2'd0, 5'd12);
        expect_after(1,  "jump_e161", 1'b0, 1'b0, 2'd0, 5'd12);
        compare("lost_after_jump", 16'(lost_cnt), 16'd1);

        // Alternating 8/9 per window relocks at edge 160 + 144 = 304.
        trim = TRIM_8;
        tick(15);                                   // edge 176
        for (int w = 1; w < 8; w++) begin
            trim = (w % 2 == 1) ? TRIM_9 : TRIM_8;
            tick(16);
        end                                         // edge 288
        trim = TRIM_8;
        expect_after(15, "alt89_e303", 1'b0, 1'b0, 2'd1, 5'd8);
        expect_after(1,  "alt89_e304", 1'b1, 1'b0, 2'd2, 5'd8);

        // div 8 -> 9 while locked: immediate unlock with one lost pulse.
        div = 5'd9;
        expect_after(1,   "div_e305", 1'b0, 1'b1, 2'd0, 5'd8);
        expect_after(1,   "div_e306", 1'b0, 1'b0, 2'd0, 5'd8);
        compare("lost_after_div", 16'(lost_cnt), 16'd2);
        expect_after(142, "div_e448", 1'b0, 1'b0, 2'd1, 5'd8);
        expect_after(1,   "div_e449", 1'b1, 1'b0, 2'd2, 5'd8);

        // div back to 8, then alternating 8/10: never locks.
        div = 5'd8;
        expect_after(1, "div2_e450", 1'b0, 1'b1, 2'd0, 5'd8);
        for (int w = 0; w < 12; w++) begin
            trim = (w % 2 == 1) ? TRIM_10 : TRIM_8;
            tick(16);
        end                                         // edge 642
        expect_after(0, "alt810_e642", 1'b0, 1'b0, 2'd1, 5'd10);
        compare("lost_after_alt810", 16'(lost_cnt), 16'd3);

        // Reset mid-ACQUIRE with full-scale trim: all outputs clear, no pulse.
        trim    = TRIM_26;
        reset_n = 1'b0;
        expect_after(1, "rst_acq", 1'b0, 1'b0, 2'd0, 5'd0);
        reset_n = 1'b1;
        expect_after(1,  "rst2_e1",  1'b0, 1'b0, 2'd0, 5'd26);
        expect_after(14, "rst2_e15", 1'b0, 1'b0, 2'd0, 5'd26);

        // div change on the window-end edge: window ignored, timer restarts.
        div = 5'd9;
        expect_after(1,  "divwe_e16", 1'b0, 1'b0, 2'd0, 5'd26);
        expect_after(15, "divwe_e31", 1'b0, 1'b0, 2'd0, 5'd26);
        expect_after(1,  "divwe_e32", 1'b0, 1'b0, 2'd1, 5'd26);
        compare("lost_total", 16'(lost_cnt), 16'd3);
        compare("sb_drained", 16'(sb.size()), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
